// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU controller: FSM states, instruction fields,
// ALU operation codes and writeback selects.
package cpu_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWriteImm,
    StGetA,
    StGetB,
    StAlu,
    StWriteReg
  } state_e;

  // Decoded instruction class; everything unsupported collapses to ClsIllegal
  typedef enum logic [2:0] {
    ClsIllegal,
    ClsMovImm,
    ClsMovReg,
    ClsAdd,
    ClsCmp,
    ClsAnd,
    ClsMvn
  } instr_class_e;

  // Opcode field values (IR[15:13])
  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;

  // Op field values (IR[12:11]) under OpcMov
  localparam logic [1:0] OpMovReg = 2'b00;
  localparam logic [1:0] OpMovImm = 2'b10;

  // ALU operation codes, equal to the op field under OpcAlu
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluCmp = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluMvn = 2'b11;

  // Writeback mux selects
  localparam logic [1:0] VselC     = 2'b00;
  localparam logic [1:0] VselImm8  = 2'b01;

  // Sign-extend an immediate of width w held in the low bits of a 16-bit word
  function automatic logic [15:0] sext16(input logic [15:0] val, input int unsigned w);
    logic [15:0] res;
    res = val;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i >= w) res[i] = val[w-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu_ctrl_instr_decoder.sv
// Combinational instruction decoder: field extraction, immediate sign
// extension and classification of the instruction word.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0]  ir_i,
  output logic [2:0]   opcode_o,
  output logic [1:0]   op_o,
  output logic [2:0]   rn_o,
  output logic [2:0]   rd_o,
  output logic [1:0]   sh_o,
  output logic [2:0]   rm_o,
  output logic [15:0]  sximm8_o,
  output logic [15:0]  sximm5_o,
  output instr_class_e iclass_o
);

  // Field extraction and immediate sign extension
  always_comb begin
    opcode_o = ir_i[15:13];
    op_o     = ir_i[12:11];
    rn_o     = ir_i[10:8];
    rd_o     = ir_i[7:5];
    sh_o     = ir_i[4:3];
    rm_o     = ir_i[2:0];
    sximm8_o = sext16({8'h00, ir_i[7:0]}, 8);
    sximm5_o = sext16({11'h000, ir_i[4:0]}, 5);
  end

  // Instruction classification; unknown opcode/op pairs are illegal
  always_comb begin
    iclass_o = ClsIllegal;
    if (ir_i[15:13] == OpcMov) begin
      if (ir_i[12:11] == OpMovImm) begin
        iclass_o = ClsMovImm;
      end else if (ir_i[12:11] == OpMovReg) begin
        iclass_o = ClsMovReg;
      end
    end else if (ir_i[15:13] == OpcAlu) begin
      unique case (ir_i[12:11])
        AluAdd:  iclass_o = ClsAdd;
        AluCmp:  iclass_o = ClsCmp;
        AluAnd:  iclass_o = ClsAnd;
        AluMvn:  iclass_o = ClsMvn;
        default: iclass_o = ClsIllegal;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU controller: instruction register plus the sequencing FSM
// that drives register-file and datapath strobes for each instruction.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_e       state_q, state_d;
  logic [15:0]  ir_q;

  logic [2:0]   opcode;
  logic [1:0]   op;
  logic [2:0]   rn;
  logic [2:0]   rd;
  logic [1:0]   sh;
  logic [2:0]   rm;
  instr_class_e iclass;

  // Ungated strobes; reset masks them before they leave the block
  logic write_raw, loada_raw, loadb_raw, loadc_raw, loads_raw;

  instr_decoder u_instr_decoder (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .op_o     (op),
    .rn_o     (rn),
    .rd_o     (rd),
    .sh_o     (sh),
    .rm_o     (rm),
    .sximm8_o (sximm8),
    .sximm5_o (sximm5),
    .iclass_o (iclass)
  );

  // State register and IR; IR only accepts a new word while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (load && (state_q == StWait)) begin
        ir_q <= in;
      end
    end
  end

  // Next-state sequencing per instruction class
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait: begin
        if (s) state_d = StDecode;
      end
      StDecode: begin
        unique case (iclass)
          ClsMovImm:                 state_d = StWriteImm;
          ClsMovReg, ClsMvn:         state_d = StGetB;
          ClsAdd, ClsAnd, ClsCmp:    state_d = StGetA;
          default:                   state_d = StWait;
        endcase
      end
      StWriteImm: state_d = StWait;
      StGetA:     state_d = StGetB;
      StGetB:     state_d = StAlu;
      // CMP only updates status, so it skips register writeback
      StAlu:      state_d = (iclass == ClsCmp) ? StWait : StWriteReg;
      StWriteReg: state_d = StWait;
      default:    state_d = StWait;
    endcase
  end

  // Per-state datapath controls; everything idles at zero by default
  always_comb begin
    w         = 1'b0;
    readnum   = 3'd0;
    writenum  = 3'd0;
    write_raw = 1'b0;
    loada_raw = 1'b0;
    loadb_raw = 1'b0;
    loadc_raw = 1'b0;
    loads_raw = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = VselC;
    shift     = 2'b00;
    ALUop     = AluAdd;
    unique case (state_q)
      StWait: begin
        w = 1'b1;
      end
      StWriteImm: begin
        writenum  = rn;
        vsel      = VselImm8;
        write_raw = 1'b1;
      end
      StGetA: begin
        readnum   = rn;
        loada_raw = 1'b1;
      end
      StGetB: begin
        readnum   = rm;
        loadb_raw = 1'b1;
      end
      StAlu: begin
        shift = sh;
        bsel  = 1'b0;
        // MOV reg passes B through the ALU by zeroing the A operand
        asel  = (iclass == ClsMovReg);
        ALUop = (opcode == OpcAlu) ? op : AluAdd;
        if (iclass == ClsCmp) begin
          loads_raw = 1'b1;
        end else begin
          loadc_raw = 1'b1;
        end
      end
      StWriteReg: begin
        writenum  = rd;
        vsel      = VselC;
        write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset suppresses strobes immediately, even mid-instruction
  always_comb begin
    write = write_raw & ~reset;
    loada = loada_raw & ~reset;
    loadb = loadb_raw & ~reset;
    loadc = loadc_raw & ~reset;
    loads = loads_raw & ~reset;
  end

endmodule
